// File: rtl/nvdla_csb_arb_pkg.sv
// Shared widths, requester id and FSM encoding for the two-requester CSB arbiter.
package nvdla_csb_arb_pkg;
  localparam int CSB_ADDR_W = 16;
  localparam int CSB_DATA_W = 32;

  typedef logic req_id_t;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;
endpackage

// File: rtl/nvdla_csb_tag_fifo.sv
// In-order FIFO of requester ids; remembers who owns each outstanding response.
module nvdla_csb_tag_fifo #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic pop,
  input  logic din,
  output logic dout,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0] mem;
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Extra pointer MSB tells full from empty when the index bits match.
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign dout    = mem[rd_ptr[AW-1:0]];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= din;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end
endmodule

// File: rtl/nvdla_csb_arb.sv
// Round-robin arbiter sharing the NVDLA CSB target port between the host bridge (r0)
// and the config sequencer (r1); responses are routed back through in-order tag FIFOs.
module nvdla_csb_arb
  import nvdla_csb_arb_pkg::*;
#(
  parameter int RD_OUTST = 4,
  parameter int WR_OUTST = 4
) (
  input  logic                  csb_clk,
  input  logic                  csb_rstn,
  input  logic                  r0_req_valid,
  output logic                  r0_req_ready,
  input  logic [CSB_ADDR_W-1:0] r0_req_addr,
  input  logic [CSB_DATA_W-1:0] r0_req_wdat,
  input  logic                  r0_req_write,
  input  logic                  r0_req_nposted,
  output logic                  r0_rsp_valid,
  output logic [CSB_DATA_W-1:0] r0_rsp_data,
  output logic                  r0_wr_complete,
  input  logic                  r1_req_valid,
  output logic                  r1_req_ready,
  input  logic [CSB_ADDR_W-1:0] r1_req_addr,
  input  logic [CSB_DATA_W-1:0] r1_req_wdat,
  input  logic                  r1_req_write,
  input  logic                  r1_req_nposted,
  output logic                  r1_rsp_valid,
  output logic [CSB_DATA_W-1:0] r1_rsp_data,
  output logic                  r1_wr_complete,
  output logic                  csb2nvdla_valid,
  input  logic                  csb2nvdla_ready,
  output logic [CSB_ADDR_W-1:0] csb2nvdla_addr,
  output logic [CSB_DATA_W-1:0] csb2nvdla_wdat,
  output logic                  csb2nvdla_write,
  output logic                  csb2nvdla_nposted,
  input  logic                  nvdla2csb_valid,
  input  logic [CSB_DATA_W-1:0] nvdla2csb_data,
  input  logic                  nvdla2csb_wr_complete,
  output logic                  arb_err,
  output logic                  dbg_state
);
  // Handshake: a request is transferred on the cycle where csb2nvdla_valid and
  // csb2nvdla_ready are both high; rN_req_ready pulses for the owner in that cycle.
  arb_state_t state, state_nxt;
  req_id_t    grant_id;
  req_id_t    pick;
  logic       rr_ptr;
  logic       elig0, elig1, any_elig;
  logic       hs;
  logic       rd_full, rd_empty, rd_head;
  logic       wr_full, wr_empty, wr_head;
  logic       rd_push, wr_push, rd_hit, wr_hit;

  assign elig0 = r0_req_valid
               && !(!r0_req_write && rd_full)
               && !(r0_req_write && r0_req_nposted && wr_full);
  assign elig1 = r1_req_valid
               && !(!r1_req_write && rd_full)
               && !(r1_req_write && r1_req_nposted && wr_full);
  assign any_elig = elig0 || elig1;
  assign pick     = rr_ptr ? (elig1 ? 1'b1 : 1'b0) : (elig0 ? 1'b0 : 1'b1);

  assign hs           = (state == GRANT) && csb2nvdla_ready;
  assign r0_req_ready = hs && (grant_id == 1'b0);
  assign r1_req_ready = hs && (grant_id == 1'b1);
  assign rd_push      = hs && !csb2nvdla_write;
  assign wr_push      = hs && csb2nvdla_write && csb2nvdla_nposted;
  assign rd_hit       = nvdla2csb_valid && !rd_empty;
  assign wr_hit       = nvdla2csb_wr_complete && !wr_empty;
  assign dbg_state    = state;

  always_ff @(posedge csb_clk or negedge csb_rstn) begin
    if (!csb_rstn) state <= IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_elig)        state_nxt = GRANT;
      GRANT:   if (csb2nvdla_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Fields are captured at grant, so the forwarded beat stays stable through GRANT.
  always_ff @(posedge csb_clk or negedge csb_rstn) begin
    if (!csb_rstn) begin
      grant_id          <= 1'b0;
      rr_ptr            <= 1'b0;
      csb2nvdla_valid   <= 1'b0;
      csb2nvdla_addr    <= '0;
      csb2nvdla_wdat    <= '0;
      csb2nvdla_write   <= 1'b0;
      csb2nvdla_nposted <= 1'b0;
    end else if ((state == IDLE) && any_elig) begin
      grant_id          <= pick;
      csb2nvdla_valid   <= 1'b1;
      csb2nvdla_addr    <= pick ? r1_req_addr    : r0_req_addr;
      csb2nvdla_wdat    <= pick ? r1_req_wdat    : r0_req_wdat;
      csb2nvdla_write   <= pick ? r1_req_write   : r0_req_write;
      csb2nvdla_nposted <= pick ? r1_req_nposted : r0_req_nposted;
    end else if (hs) begin
      csb2nvdla_valid <= 1'b0;
      rr_ptr          <= ~grant_id;
    end
  end

  always_ff @(posedge csb_clk or negedge csb_rstn) begin
    if (!csb_rstn) begin
      r0_rsp_valid   <= 1'b0;
      r1_rsp_valid   <= 1'b0;
      r0_rsp_data    <= '0;
      r1_rsp_data    <= '0;
      r0_wr_complete <= 1'b0;
      r1_wr_complete <= 1'b0;
      arb_err        <= 1'b0;
    end else begin
      r0_rsp_valid   <= rd_hit && (rd_head == 1'b0);
      r1_rsp_valid   <= rd_hit && (rd_head == 1'b1);
      r0_wr_complete <= wr_hit && (wr_head == 1'b0);
      r1_wr_complete <= wr_hit && (wr_head == 1'b1);
      if (rd_hit && (rd_head == 1'b0)) r0_rsp_data <= nvdla2csb_data;
      if (rd_hit && (rd_head == 1'b1)) r1_rsp_data <= nvdla2csb_data;
      // Orphan responses are sticky errors; only reset clears them.
      if ((nvdla2csb_valid && rd_empty) || (nvdla2csb_wr_complete && wr_empty))
        arb_err <= 1'b1;
    end
  end

  nvdla_csb_tag_fifo #(.DEPTH(RD_OUTST)) u_rd_tags (
    .clk   (csb_clk),
    .rst_n (csb_rstn),
    .push  (rd_push),
    .pop   (nvdla2csb_valid),
    .din   (grant_id),
    .dout  (rd_head),
    .full  (rd_full),
    .empty (rd_empty)
  );

  nvdla_csb_tag_fifo #(.DEPTH(WR_OUTST)) u_wr_tags (
    .clk   (csb_clk),
    .rst_n (csb_rstn),
    .push  (wr_push),
    .pop   (nvdla2csb_wr_complete),
    .din   (grant_id),
    .dout  (wr_head),
    .full  (wr_full),
    .empty (wr_empty)
  );
endmodule

// File: tb/tb_nvdla_csb_arb.sv
// Bench for nvdla_csb_arb: directed scenarios, negedge monitor and expected-value queues.
module tb_nvdla_csb_arb;
  logic        csb_clk = 1'b0;
  logic        csb_rstn = 1'b0;
  logic        r0_req_valid = 0, r0_req_write = 0, r0_req_nposted = 0;
  logic [15:0] r0_req_addr = '0;
  logic [31:0] r0_req_wdat = '0;
  logic        r1_req_valid = 0, r1_req_write = 0, r1_req_nposted = 0;
  logic [15:0] r1_req_addr = '0;
  logic [31:0] r1_req_wdat = '0;
  logic        csb2nvdla_ready = 1'b1;
  logic        nvdla2csb_valid = 0, nvdla2csb_wr_complete = 0;
  logic [31:0] nvdla2csb_data = '0;

  logic        r0_req_ready, r1_req_ready;
  logic        r0_rsp_valid, r1_rsp_valid, r0_wr_complete, r1_wr_complete;
  logic [31:0] r0_rsp_data, r1_rsp_data;
  logic        csb2nvdla_valid, csb2nvdla_write, csb2nvdla_nposted;
  logic [15:0] csb2nvdla_addr;
  logic [31:0] csb2nvdla_wdat;
  logic        arb_err, dbg_state;

  int checks = 0;
  int errors = 0;

  logic [50:0] beat_q[$];  // {id, nposted, write, addr, wdat}
  logic [32:0] rsp_q[$];   // {id, data}
  logic [0:0]  wc_q[$];    // id

  always #5 csb_clk = ~csb_clk;

  nvdla_csb_arb #(.RD_OUTST(4), .WR_OUTST(4)) dut (
    .csb_clk(csb_clk), .csb_rstn(csb_rstn),
    .r0_req_valid(r0_req_valid), .r0_req_ready(r0_req_ready), .r0_req_addr(r0_req_addr),
    .r0_req_wdat(r0_req_wdat), .r0_req_write(r0_req_write), .r0_req_nposted(r0_req_nposted),
    .r0_rsp_valid(r0_rsp_valid), .r0_rsp_data(r0_rsp_data), .r0_wr_complete(r0_wr_complete),
    .r1_req_valid(r1_req_valid), .r1_req_ready(r1_req_ready), .r1_req_addr(r1_req_addr),
    .r1_req_wdat(r1_req_wdat), .r1_req_write(r1_req_write), .r1_req_nposted(r1_req_nposted),
    .r1_rsp_valid(r1_rsp_valid), .r1_rsp_data(r1_rsp_data), .r1_wr_complete(r1_wr_complete),
    .csb2nvdla_valid(csb2nvdla_valid), .csb2nvdla_ready(csb2nvdla_ready),
    .csb2nvdla_addr(csb2nvdla_addr), .csb2nvdla_wdat(csb2nvdla_wdat),
    .csb2nvdla_write(csb2nvdla_write), .csb2nvdla_nposted(csb2nvdla_nposted),
    .nvdla2csb_valid(nvdla2csb_valid), .nvdla2csb_data(nvdla2csb_data),
    .nvdla2csb_wr_complete(nvdla2csb_wr_complete),
    .arb_err(arb_err), .dbg_state(dbg_state)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [50:0] beat(input logic id, input logic np, input logic wr,
                                       input logic [15:0] a, input logic [31:0] d);
    return {id, np, wr, a, d};
  endfunction

  // Monitor: every transfer and every response pulse is matched against the queues.
  always @(negedge csb_clk) begin
    logic [50:0] eb;
    logic [32:0] er;
    logic [0:0]  ew;
    if (csb2nvdla_valid && csb2nvdla_ready) begin
      check_eq("req_ready_onehot", 64'(int'(r0_req_ready) + int'(r1_req_ready)), 64'd1);
      if (beat_q.size() == 0) check_eq("beat_unexpected", 1, 0);
      else begin
        eb = beat_q.pop_front();
        check_eq("beat", {r1_req_ready, csb2nvdla_nposted, csb2nvdla_write,
                          csb2nvdla_addr, csb2nvdla_wdat}, eb);
      end
    end else begin
      check_eq("req_ready_idle", r0_req_ready | r1_req_ready, 0);
    end
    if (r0_rsp_valid || r1_rsp_valid) begin
      check_eq("rsp_onehot", r0_rsp_valid & r1_rsp_valid, 0);
      if (rsp_q.size() == 0) check_eq("rsp_unexpected", 1, 0);
      else begin
        er = rsp_q.pop_front();
        check_eq("rsp", {r1_rsp_valid, r1_rsp_valid ? r1_rsp_data : r0_rsp_data}, er);
      end
    end
    if (r0_wr_complete || r1_wr_complete) begin
      check_eq("wc_onehot", r0_wr_complete & r1_wr_complete, 0);
      if (wc_q.size() == 0) check_eq("wc_unexpected", 1, 0);
      else begin
        ew = wc_q.pop_front();
        check_eq("wc_id", r1_wr_complete, ew);
      end
    end
  end

  task automatic do_reset();
    check_eq("beat_q_drained", beat_q.size(), 0);
    check_eq("rsp_q_drained", rsp_q.size(), 0);
    check_eq("wc_q_drained", wc_q.size(), 0);
    csb_rstn = 1'b0;
    r0_req_valid = 0; r1_req_valid = 0;
    nvdla2csb_valid = 0; nvdla2csb_wr_complete = 0;
    csb2nvdla_ready = 1'b1;
    repeat (2) @(posedge csb_clk);
    #1 csb_rstn = 1'b1;
  endtask

  task automatic drive_req(input logic id, input logic [15:0] a, input logic [31:0] d,
                           input logic wr, input logic np);
    bit got = 0;
    if (id == 1'b0) begin
      r0_req_valid = 1; r0_req_addr = a; r0_req_wdat = d; r0_req_write = wr; r0_req_nposted = np;
    end else begin
      r1_req_valid = 1; r1_req_addr = a; r1_req_wdat = d; r1_req_write = wr; r1_req_nposted = np;
    end
    for (int n = 0; n < 50; n++) begin
      @(negedge csb_clk);
      if ((id == 1'b0 && r0_req_ready) || (id == 1'b1 && r1_req_ready)) begin
        got = 1;
        break;
      end
    end
    @(posedge csb_clk);
    #1;
    if (id == 1'b0) r0_req_valid = 0; else r1_req_valid = 0;
    if (!got) check_eq("req_timeout", 0, 1);
  endtask

  task automatic drive_rsp(input logic v, input logic [31:0] d, input logic wc);
    nvdla2csb_valid = v; nvdla2csb_data = d; nvdla2csb_wr_complete = wc;
    @(posedge csb_clk);
    #1;
    nvdla2csb_valid = 0; nvdla2csb_wr_complete = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w0[4];
    logic [31:0] w1[4];
    logic [31:0] rd[5];
    logic [31:0] wv;

    // Reset state
    do_reset();
    @(negedge csb_clk);
    check_eq("rst_csb_valid", csb2nvdla_valid, 0);
    check_eq("rst_arb_err", arb_err, 0);
    check_eq("rst_rsp", {r0_rsp_valid, r1_rsp_valid, r0_wr_complete, r1_wr_complete}, 0);
    check_eq("rst_state", dbg_state, 0);
    check_eq("rst_fields", {csb2nvdla_addr, csb2nvdla_wdat, csb2nvdla_write}, 0);
    @(posedge csb_clk); #1;

    // Single r0 read, one-cycle grant latency, data returned two cycles later
    beat_q.push_back(beat(0, 0, 0, 16'h1000, 32'h0));
    r0_req_valid = 1; r0_req_addr = 16'h1000; r0_req_wdat = 0; r0_req_write = 0; r0_req_nposted = 0;
    @(negedge csb_clk);
    check_eq("lat_before", csb2nvdla_valid, 0);
    @(negedge csb_clk);
    check_eq("lat_one_cycle", csb2nvdla_valid, 1);
    check_eq("t1_ready", r0_req_ready, 1);
    @(posedge csb_clk); #1;
    r0_req_valid = 0;
    @(posedge csb_clk); #1;
    rsp_q.push_back({1'b0, 32'hDEADBEEF});
    drive_rsp(1, 32'hDEADBEEF, 0);
    @(negedge csb_clk);
    check_eq("t1_rsp_valid", r0_rsp_valid, 1);
    check_eq("t1_rsp_data", r0_rsp_data, 32'hDEADBEEF);
    check_eq("t1_r1_quiet", r1_rsp_valid, 0);
    repeat (2) @(posedge csb_clk); #1;

    // Both requesters stream posted writes; grants must alternate r0,r1,...
    do_reset();
    for (int i = 0; i < 4; i++) begin
      w0[i] = $urandom; w1[i] = $urandom;
      beat_q.push_back(beat(0, 0, 1, 16'h2000 + 16'(i), w0[i]));
      beat_q.push_back(beat(1, 0, 1, 16'h3000 + 16'(i), w1[i]));
    end
    fork
      begin
        for (int i = 0; i < 4; i++) drive_req(0, 16'h2000 + 16'(i), w0[i], 1, 0);
      end
      begin
        for (int i = 0; i < 4; i++) drive_req(1, 16'h3000 + 16'(i), w1[i], 1, 0);
      end
    join

    // Target stalls 5 cycles; the r0 beat must hold and r1 must wait
    csb2nvdla_ready = 0;
    beat_q.push_back(beat(0, 0, 1, 16'h4000, 32'hA5A50001));
    beat_q.push_back(beat(1, 0, 0, 16'h5000, 32'h0));
    fork
      drive_req(0, 16'h4000, 32'hA5A50001, 1, 0);
      drive_req(1, 16'h5000, 32'h0, 0, 0);
      begin
        for (int n = 0; n < 20 && !csb2nvdla_valid; n++) @(negedge csb_clk);
        check_eq("stall_granted", csb2nvdla_valid, 1);
        repeat (5) begin
          check_eq("stall_addr", csb2nvdla_addr, 16'h4000);
          check_eq("stall_wdat", csb2nvdla_wdat, 32'hA5A50001);
          check_eq("stall_write", csb2nvdla_write, 1);
          check_eq("stall_no_switch", r1_req_ready, 0);
          @(negedge csb_clk);
        end
        @(posedge csb_clk); #1;
        csb2nvdla_ready = 1;
      end
    join
    rsp_q.push_back({1'b1, 32'h12345678});
    drive_rsp(1, 32'h12345678, 0);
    repeat (2) @(posedge csb_clk); #1;

    // Read tag FIFO full: 5th r0 read held, r1 posted write still goes through
    do_reset();
    for (int i = 0; i < 5; i++) rd[i] = $urandom;
    wv = $urandom;
    for (int i = 0; i < 4; i++) beat_q.push_back(beat(0, 0, 0, 16'h6000 + 16'(i), 32'h0));
    beat_q.push_back(beat(1, 0, 1, 16'h7000, wv));
    beat_q.push_back(beat(0, 0, 0, 16'h6004, 32'h0));
    for (int i = 0; i < 4; i++) drive_req(0, 16'h6000 + 16'(i), 32'h0, 0, 0);
    fork
      drive_req(0, 16'h6004, 32'h0, 0, 0);
      begin
        repeat (3) begin
          @(negedge csb_clk);
          check_eq("rd_full_block", r0_req_ready, 0);
        end
        @(posedge csb_clk); #1;
        drive_req(1, 16'h7000, wv, 1, 0);
        repeat (2) @(posedge csb_clk); #1;
        rsp_q.push_back({1'b0, rd[0]});
        drive_rsp(1, rd[0], 0);
      end
    join
    for (int i = 1; i < 5; i++) begin
      rsp_q.push_back({1'b0, rd[i]});
      drive_rsp(1, rd[i], 0);
    end
    repeat (3) @(posedge csb_clk); #1;

    // r0 read and r1 non-posted write complete in the same cycle
    do_reset();
    wv = $urandom;
    beat_q.push_back(beat(0, 0, 0, 16'h8000, 32'h0));
    beat_q.push_back(beat(1, 1, 1, 16'h9000, wv));
    drive_req(0, 16'h8000, 32'h0, 0, 0);
    drive_req(1, 16'h9000, wv, 1, 1);
    rsp_q.push_back({1'b0, 32'hCAFEF00D});
    wc_q.push_back(1'b1);
    drive_rsp(1, 32'hCAFEF00D, 1);
    @(negedge csb_clk);
    check_eq("sim_rsp", r0_rsp_valid, 1);
    check_eq("sim_wc", r1_wr_complete, 1);
    check_eq("sim_wc_r0", r0_wr_complete, 0);
    check_eq("sim_no_err", arb_err, 0);
    @(posedge csb_clk); #1;

    // Orphan read return: no pulse, sticky arb_err until reset
    do_reset();
    drive_rsp(1, 32'hBAD0BAD0, 0);
    @(negedge csb_clk);
    check_eq("orphan_no_rsp", {r0_rsp_valid, r1_rsp_valid}, 0);
    check_eq("orphan_err", arb_err, 1);
    repeat (5) @(posedge csb_clk);
    @(negedge csb_clk);
    check_eq("err_sticky", arb_err, 1);
    @(posedge csb_clk); #1;
    do_reset();
    @(negedge csb_clk);
    check_eq("err_cleared", arb_err, 0);
    @(posedge csb_clk); #1;

    // Reset with a read outstanding drops the tag; the late return is an orphan
    beat_q.push_back(beat(0, 0, 0, 16'hA000, 32'h0));
    drive_req(0, 16'hA000, 32'h0, 0, 0);
    do_reset();
    drive_rsp(1, 32'h0BADF00D, 0);
    @(negedge csb_clk);
    check_eq("midrst_no_rsp", r0_rsp_valid, 0);
    check_eq("midrst_err", arb_err, 1);
    @(posedge csb_clk); #1;
    do_reset();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
